// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter for 5-9 bit words with optional odd/even/stick parity and 1/1.5/2 stop bits.
// Line-break support (BREAK state, brk_pend) is built only when UART_TX_BREAK_EN is defined.
module uart_tx_frame #(
  parameter int OV_SAMP   = 16,
  parameter int MAX_WIDTH = 9
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_baud,
  input  logic                 i_tx_en,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [MAX_WIDTH-1:0] i_data,
  input  logic [2:0]           i_width_sel,
  input  logic [2:0]           i_parity_sel,
  input  logic [1:0]           i_stop_sel,
  input  logic                 i_break,
  output logic                 o_tx,
  output logic                 o_tx_done,
  output logic                 o_busy
);

  localparam int            CW          = $clog2(2 * OV_SAMP);
  localparam logic [CW-1:0] BIT_LAST    = CW'(OV_SAMP - 1);
  localparam logic [CW-1:0] STOP15_LAST = CW'(3 * OV_SAMP / 2 - 1);
  localparam logic [CW-1:0] STOP2_LAST  = CW'(2 * OV_SAMP - 1);
  localparam logic [3:0]    WMAX        = 4'(MAX_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]        cnt, cnt_last;
  logic [3:0]           bit_idx, width_q, width_dec;
  logic [MAX_WIDTH-1:0] shift_q, width_mask;
  logic                 par_on_q, par_bit_q, par_bit_dec;
  logic [1:0]           stop_q;
  logic                 brk_stop_q;
  logic                 brk_pend, tick_end, last_stop, xfer;

`ifdef UART_TX_BREAK_EN
  assign brk_pend = i_break;
`else
  logic unused_break;
  assign unused_break = i_break;
  assign brk_pend     = 1'b0;
`endif

  // Decode width and precompute the parity bit so the frame only carries the result.
  always_comb begin
    width_dec = (i_width_sel > 3'd4) ? WMAX : 4'(i_width_sel) + 4'd5;
    if (width_dec > WMAX) width_dec = WMAX;
    for (int i = 0; i < MAX_WIDTH; i++) width_mask[i] = (4'(i) < width_dec);
    par_bit_dec = i_parity_sel[1] ? i_parity_sel[0]
                                  : (^(i_data & width_mask)) ^ i_parity_sel[0];
  end

  // Break recovery always uses a single stop bit regardless of the latched stop select.
  always_comb begin
    cnt_last = BIT_LAST;
    if (state == STOP && !brk_stop_q) begin
      case (stop_q)
        2'b00:   cnt_last = BIT_LAST;
        2'b01:   cnt_last = STOP15_LAST;
        default: cnt_last = STOP2_LAST;
      endcase
    end
  end

  assign tick_end  = i_baud && (cnt == cnt_last);
  assign last_stop = (state == STOP) && tick_end;
  assign xfer      = i_valid && o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (brk_pend) state_nxt = BREAK;
              else if (xfer) state_nxt = START;
      START:  if (tick_end) state_nxt = DATA;
      DATA:   if (tick_end && bit_idx == width_q - 4'd1)
                state_nxt = par_on_q ? PARITY : STOP;
      PARITY: if (tick_end) state_nxt = STOP;
      STOP:   if (tick_end) begin
                if (brk_stop_q)    state_nxt = IDLE;
                else if (xfer)     state_nxt = START;
                else if (brk_pend) state_nxt = BREAK;
                else               state_nxt = IDLE;
              end
`ifdef UART_TX_BREAK_EN
      BREAK:  if (!i_break) state_nxt = STOP;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (state != IDLE);
    o_tx_done = last_stop && !brk_stop_q;
    o_ready   = i_tx_en && !brk_pend && ((state == IDLE) || o_tx_done);
    case (state)
      START, BREAK: o_tx = 1'b0;
      DATA:         o_tx = shift_q[0];
      PARITY:       o_tx = par_bit_q;
      default:      o_tx = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shift_q    <= '0;
      width_q    <= '0;
      par_on_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_q     <= 2'b00;
      brk_stop_q <= 1'b0;
    end else begin
      if (state == IDLE || state == BREAK || tick_end) cnt <= '0;
      else if (i_baud)                                 cnt <= cnt + 1'b1;

      if (state != DATA)  bit_idx <= '0;
      else if (tick_end)  bit_idx <= bit_idx + 4'd1;

      if (xfer) begin
        shift_q    <= i_data;
        width_q    <= width_dec;
        par_on_q   <= i_parity_sel[2];
        par_bit_q  <= par_bit_dec;
        stop_q     <= i_stop_sel;
        brk_stop_q <= 1'b0;
      end else begin
        if (state == DATA && tick_end) shift_q <= shift_q >> 1;
        if (state == BREAK && state_nxt == STOP) brk_stop_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: self-checking bench for uart_tx_frame.
// The reference is a per-baud-tick model of the serial line built from the frame rules.
module tb_uart_tx_frame;

  localparam int OV = 16;
  localparam int MW = 9;

  logic          i_clk, i_rst_n, i_baud, i_tx_en, i_valid, i_break;
  logic [MW-1:0] i_data;
  logic [2:0]    i_width_sel, i_parity_sel;
  logic [1:0]    i_stop_sel;
  logic          o_ready, o_tx, o_tx_done, o_busy;

  uart_tx_frame #(.OV_SAMP(OV), .MAX_WIDTH(MW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_baud       (i_baud),
    .i_tx_en      (i_tx_en),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .i_width_sel  (i_width_sel),
    .i_parity_sel (i_parity_sel),
    .i_stop_sel   (i_stop_sel),
    .i_break      (i_break),
    .o_tx         (o_tx),
    .o_tx_done    (o_tx_done),
    .o_busy       (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct packed {
    logic lvl;
    logic last;
  } tick_t;

  tick_t         exp_q[$];
  logic [MW-1:0] w_data[$];
  logic [2:0]    w_wsel[$];
  logic [2:0]    w_psel[$];
  logic [1:0]    w_ssel[$];
  int            checks   = 0;
  int            failures = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void add_word(input logic [MW-1:0] d, input logic [2:0] ws,
                                   input logic [2:0] ps, input logic [1:0] ss);
    w_data.push_back(d);
    w_wsel.push_back(ws);
    w_psel.push_back(ps);
    w_ssel.push_back(ss);
  endfunction

  function automatic void push_ticks(input logic lvl, input int n, input logic mark_last);
    for (int t = 0; t < n; t++) begin
      tick_t tk;
      tk.lvl  = lvl;
      tk.last = mark_last && (t == n - 1);
      exp_q.push_back(tk);
    end
  endfunction

  // Expected line for one frame, one entry per baud tick.
  function automatic void push_frame(input logic [MW-1:0] d, input logic [2:0] ws,
                                     input logic [2:0] ps, input logic [1:0] ss);
    int            w;
    int            stop_ticks;
    logic [MW-1:0] low;
    logic          par;
    w = (ws > 3'd4) ? MW : 5 + int'(ws);
    if (w > MW) w = MW;
    low = '0;
    for (int b = 0; b < w; b++) low[b] = d[b];
    push_ticks(1'b0, OV, 1'b0);
    for (int b = 0; b < w; b++) push_ticks(d[b], OV, 1'b0);
    if (ps[2]) begin
      par = ps[1] ? ps[0] : ((($countones(low) % 2) == 1) ^ ps[0]);
      push_ticks(par, OV, 1'b0);
    end
    stop_ticks = (ss == 2'b00) ? OV : (ss == 2'b01) ? (OV * 3) / 2 : 2 * OV;
    push_ticks(1'b1, stop_ticks, 1'b1);
  endfunction

  task automatic scramble();
    i_data       = MW'($urandom);
    i_width_sel  = 3'($urandom_range(0, 7));
    i_parity_sel = 3'($urandom_range(0, 7));
    i_stop_sel   = 2'($urandom_range(0, 3));
  endtask

  // Streams the queued words cycle by cycle and compares every cycle against the line model.
  task automatic apply_stimulus(input string tag, input bit rnd_baud, input int en_off_at,
                                input int exp_sent);
    int   n, sent, cyc, tail, dones;
    int   bad_tx, bad_rdy, bad_busy, bad_done;
    logic empty, e_tx, e_last, e_done, e_rdy;
    n = w_data.size();
    sent = 0; cyc = 0; tail = 0; dones = 0;
    bad_tx = 0; bad_rdy = 0; bad_busy = 0; bad_done = 0;
    exp_q.delete();
    while (cyc < 20000 && tail < 20) begin
      i_baud = rnd_baud ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      if (en_off_at >= 0 && cyc == en_off_at) i_tx_en = 1'b0;
`ifndef UART_TX_BREAK_EN
      i_break = 1'($urandom_range(0, 1));
`endif
      scramble();
      i_valid = (sent < n);
      if (sent < n) begin
        i_data       = w_data[sent];
        i_width_sel  = w_wsel[sent];
        i_parity_sel = w_psel[sent];
        i_stop_sel   = w_ssel[sent];
      end
      @(negedge i_clk);
      empty  = (exp_q.size() == 0);
      e_tx   = empty ? 1'b1 : exp_q[0].lvl;
      e_last = !empty && exp_q[0].last;
      e_done = i_baud && e_last;
      e_rdy  = i_tx_en && (empty || e_done);
      if (o_tx !== e_tx)       bad_tx++;
      if (o_ready !== e_rdy)   bad_rdy++;
      if (o_busy !== !empty)   bad_busy++;
      if (o_tx_done !== e_done) bad_done++;
      if (o_tx_done === 1'b1)  dones++;
      if (i_baud && !empty) void'(exp_q.pop_front());
      if (i_valid && e_rdy) begin
        push_frame(w_data[sent], w_wsel[sent], w_psel[sent], w_ssel[sent]);
        sent++;
      end
      if (!((sent < n && i_tx_en) || exp_q.size() != 0)) tail++;
      @(posedge i_clk);
      #1;
      cyc++;
    end
    check_output({tag, " line"},    32'(bad_tx),   32'd0);
    check_output({tag, " ready"},   32'(bad_rdy),  32'd0);
    check_output({tag, " busy"},    32'(bad_busy), 32'd0);
    check_output({tag, " done"},    32'(bad_done), 32'd0);
    check_output({tag, " words"},   32'(sent),     32'(exp_sent));
    check_output({tag, " npulse"},  32'(dones),    32'(exp_sent));
    check_output({tag, " timeout"}, 32'(cyc >= 20000), 32'd0);
    i_valid = 1'b0;
    i_tx_en = 1'b1;
    i_break = 1'b0;
    i_baud  = 1'b1;
    w_data.delete(); w_wsel.delete(); w_psel.delete(); w_ssel.delete();
  endtask

  initial begin
    int done_at, bad, high;
    i_rst_n = 1'b0; i_baud = 1'b1; i_tx_en = 1'b1; i_valid = 1'b0; i_break = 1'b0;
    i_data = '0; i_width_sel = 3'd3; i_parity_sel = 3'd0; i_stop_sel = 2'd0;

    @(negedge i_clk);
    check_output("rst tx",    32'(o_tx),      32'd1);
    check_output("rst busy",  32'(o_busy),    32'd0);
    check_output("rst done",  32'(o_tx_done), 32'd0);
    check_output("rst ready", 32'(o_ready),   32'd1);
    i_tx_en = 1'b0;
    #1 check_output("rst ready en0", 32'(o_ready), 32'd0);
`ifdef UART_TX_BREAK_EN
    i_tx_en = 1'b1; i_break = 1'b1;
    #1 check_output("rst ready brk", 32'(o_ready), 32'd0);
    i_break = 1'b0;
`endif
    @(posedge i_clk);
    #1 i_rst_n = 1'b1; i_tx_en = 1'b1;

    $display("[TB] 8N1 0x0A5");
    add_word(9'h0A5, 3'd3, 3'b000, 2'b00);
    apply_stimulus("8n1", 1'b0, -1, 1);

    $display("[TB] 9-bit parity variants on 0x1FF");
    add_word(9'h1FF, 3'd4, 3'b101, 2'b00);
    add_word(9'h1FF, 3'd4, 3'b100, 2'b00);
    add_word(9'h1FF, 3'd4, 3'b111, 2'b00);
    apply_stimulus("par9", 1'b0, -1, 3);

    $display("[TB] 7E1.5 0x55 with bus config churn");
    add_word(9'h055, 3'd2, 3'b100, 2'b01);
    apply_stimulus("7e15", 1'b0, -1, 1);

    $display("[TB] 5N2 back-to-back");
    add_word(9'h015, 3'd0, 3'b000, 2'b10);
    add_word(9'h00A, 3'd0, 3'b000, 2'b11);
    add_word(9'h1F3, 3'd0, 3'b000, 2'b10);
    apply_stimulus("5n2 stream", 1'b0, -1, 3);

    $display("[TB] random frames, random baud");
    for (int k = 0; k < 16; k++)
      add_word(MW'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               2'($urandom_range(0, 3)));
    apply_stimulus("random", 1'b1, -1, 16);

    $display("[TB] enable dropped mid-frame");
    add_word(9'h0C3, 3'd3, 3'b101, 2'b00);
    add_word(9'h03C, 3'd3, 3'b101, 2'b00);
    apply_stimulus("en drop", 1'b0, 30, 1);

    $display("[TB] reset during data bit 3");
    i_data = 9'h0A5; i_width_sel = 3'd3; i_parity_sel = 3'd0; i_stop_sel = 2'd0;
    i_valid = 1'b1; i_baud = 1'b1;
    @(negedge i_clk);
    check_output("mrst ready", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    repeat (70) @(posedge i_clk);
    #2;
    check_output("mrst bit3",  32'(o_tx),   32'd0);
    check_output("mrst inframe", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check_output("mrst tx",   32'(o_tx),      32'd1);
    check_output("mrst busy", 32'(o_busy),    32'd0);
    check_output("mrst done", 32'(o_tx_done), 32'd0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    add_word(9'h13C, 3'd4, 3'b101, 2'b10);
    apply_stimulus("post rst", 1'b0, -1, 1);

`ifdef UART_TX_BREAK_EN
    $display("[TB] break raised mid-frame");
    i_data = 9'h05A; i_width_sel = 3'd3; i_parity_sel = 3'd0; i_stop_sel = 2'd0;
    i_valid = 1'b1;
    @(negedge i_clk);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    done_at = -1; bad = 0;
    for (int k = 0; k < 400 && done_at < 0; k++) begin
      if (k >= 50) i_break = 1'b1;
      @(negedge i_clk);
      if (k >= 50 && o_ready !== 1'b0) bad++;
      if (o_tx_done === 1'b1) done_at = k;
      @(posedge i_clk);
      #1;
    end
    check_output("brk frame end", 32'(done_at), 32'd159);
    for (int k = 0; k < 30; k++) begin
      @(negedge i_clk);
      if (o_tx !== 1'b0 || o_busy !== 1'b1 || o_ready !== 1'b0) bad++;
      @(posedge i_clk);
      #1;
    end
    i_break = 1'b0;
    high = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge i_clk);
      if (o_busy !== 1'b1) break;
      if (o_tx === 1'b1) high++;
      if (o_ready !== 1'b0 || o_tx_done !== 1'b0) bad++;
      @(posedge i_clk);
      #1;
    end
    check_output("brk hold",     32'(bad),    32'd0);
    check_output("brk recovery", 32'(high),   32'(OV));
    check_output("brk idle",     32'(o_busy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, the next generation of the team's serial TX engine. Serialises 5-9 bit words with optional parity (odd, even or stick) and 1, 1.5 or 2 stop bits. Takes words over a valid/ready handshake so it can stream back-to-back frames from the TX FIFO. Can also drive a line break. It sits between the TX FIFO and the serial pin and is paced by the shared oversampling baud tick.

## Interface
- OV_SAMP, 16: `i_baud` ticks per bit; even, ≥4.
- MAX_WIDTH, 9: data port width; 8 or 9.
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_baud  in  1  oversample tick, one-cycle pulse
- i_tx_en  in  1  transmitter enable
- i_valid  in  1  word available
- o_ready  out  1  block accepts word this cycle
- i_data  in  MAX_WIDTH  word, LSB transmitted first
- i_width_sel  in  3  0..4 selects 5..9 bits; values >4, or widths above MAX_WIDTH, use MAX_WIDTH
- i_parity_sel  in  3  [2] parity on, [1] stick, [0] odd (non-stick) or stick value
- i_stop_sel  in  2  00: 1 bit, 01: 1.5 bits, 1x: 2 bits
- i_break  in  1  break request
- o_tx  out  1  serial line
- o_tx_done  out  1  one-cycle pulse at end of each frame's last stop tick
- o_busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- Handshake: a transfer occurs on `i_valid & o_ready`.
  - `o_ready` = `i_tx_en & ~brk_pend` when the block is in IDLE.
  - `o_ready` = `i_tx_en & ~brk_pend` during the final stop tick, i.e. STOP with the last count reached and `i_baud` high.
  - `o_ready` is 0 at all other times.
- On transfer, the block latches `i_data`, the decoded width W, the parity select and the stop select. Each latched value is held for the whole frame; mid-frame config changes are ignored. The next state is START.
- Line levels by state:
  - START: `o_tx`=0 for OV_SAMP ticks.
  - DATA: `o_tx`=`shift[idx]` for OV_SAMP ticks per bit, idx 0..W-1.
  - PARITY: entered only if parity is on; lasts OV_SAMP ticks.
  - STOP: `o_tx`=1.
- Parity bit value:
  - Stick: bit = [0].
  - Non-stick: bit = XOR(`data[W-1:0]`) ^ [0]. [0]=0 gives even parity, [0]=1 gives odd parity.
- Stop length: OV_SAMP ticks for 1 bit, 3·OV_SAMP/2 for 1.5 bits, 2·OV_SAMP for 2 bits. The STOP tick counter is $clog2(2·OV_SAMP) bits wide.
- End of STOP: `o_tx_done` pulses. The next state is START if a transfer occurred on that cycle, otherwise BREAK if `brk_pend`, otherwise IDLE.
- Break handling:
  - `brk_pend` is set while `i_break`=1.
  - From IDLE, break takes priority over `i_valid`.
  - A mid-frame request waits until the frame finishes.
  - BREAK drives `o_tx`=0 while `i_break`=1. On release it enters STOP with a forced 1-bit length (OV_SAMP ticks), with no `o_tx_done` pulse, then goes to IDLE.
- `i_tx_en` deasserted mid-frame: the current frame completes and no further words are accepted.
- All bit-timing counters advance only on cycles with `i_baud`=1. A count reaches its end on the tick where it equals its limit−1; the counter then clears to 0.

## Timing
- Reset values:
  - state IDLE, counters 0, data register 0.
  - `o_tx`=1, `o_busy`=0, `o_tx_done`=0.
  - `o_ready` = `i_tx_en & ~i_break`.
- Reset asserted mid-frame: `o_tx` returns to 1 asynchronously, with no partial stop bit and no `o_tx_done` pulse.
- START (`o_tx`=0) begins on the clock cycle after the transfer.
- Frame length = OV_SAMP·(1+W+P) + stop ticks, where P=1 if parity is on, else 0.
- Back-to-back frames have zero idle ticks between them.
- `o_tx_done` is registered-free: it is decoded combinationally from the final stop tick, in the same cycle that `o_ready` can accept the next word.

## Configuration
- Macro `UART_TX_BREAK_EN`.
  - Defined: the BREAK state and `brk_pend` logic exist as described above.
  - Undefined: `i_break` remains on the port list but is ignored, `brk_pend` is tied to 0, and the BREAK state is not synthesised.

## Test plan
- OV_SAMP=16, `i_baud` every cycle, 8N1, `i_data`=0x0A5:
  - `o_tx` = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles.
  - `o_tx_done` pulses on cycle 160 after START.
  - `o_ready`=0 during the frame.
- 9-bit data, odd parity, `i_data`=0x1FF: parity bit=0 (nine ones already odd). With even parity the bit=1. With stick [0]=1 the bit=1.
- 7E1.5, `i_data`=0x55: the stop high phase lasts exactly 24 ticks. Changing `i_stop_sel` mid-frame does not alter it.
- `i_valid` held high with three words, 5N2: three frames at 128 ticks each, no gap between them, and `o_tx_done` pulses three times.
- Break with the macro defined:
  - `i_break` raised mid-frame: the frame finishes, then `o_tx`=0 for the hold time, then 16 high ticks, then IDLE.
  - `o_ready`=0 throughout.
  - Without the macro: the line is unaffected.
- Reset asserted at DATA bit 3: `o_tx`=1, `o_busy`=0 immediately. After release, a new word transmits cleanly.
